// File: rtl/simd_pipe_ctrl.sv
// simd_pipe_ctrl: three-stage Load/Execute/Store control pipeline with step divider, stall and RAW interlock
module simd_pipe_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int OP_SEL_WIDTH = 4,
  parameter int STEP_CYCLES  = 2,
  parameter int HAZARD_CHECK = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    ins_valid,
  output logic                    ins_ready,
  input  logic [ADDR_WIDTH-1:0]   ins_a_addr,
  input  logic [ADDR_WIDTH-1:0]   ins_b_addr,
  input  logic [ADDR_WIDTH-1:0]   ins_r_addr,
  input  logic [OP_SEL_WIDTH-1:0] ins_pe_op,
  input  logic [1:0]              ins_dot_ctrl,
  input  logic                    ins_wen,
  input  logic                    ins_r_sel,
  output logic [ADDR_WIDTH-1:0]   bram_a_addr,
  output logic [ADDR_WIDTH-1:0]   bram_b_addr,
  output logic                    exec_valid,
  output logic [OP_SEL_WIDTH-1:0] exec_pe_op,
  output logic [1:0]              exec_dot_ctrl,
  output logic                    step,
  output logic [ADDR_WIDTH-1:0]   bram_r_addr,
  output logic                    bram_r_wen,
  output logic                    store_r_sel,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    hazard_cnt
);
  localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic l_v, l_wen, l_rsel, x_v, x_wen, x_rsel, s_v, s_wen, s_rsel;
  logic [ADDR_WIDTH-1:0] l_a, l_b, l_r, x_r, s_r;
  logic [OP_SEL_WIDTH-1:0] l_op, x_op;
  logic [1:0] l_dot, x_dot;
  logic hazard, xfer, raw_l, raw_x;
  assign step = (cnt == CW'(STEP_CYCLES - 1)) && !stall;
  assign raw_l = l_v && l_wen && (l_r == ins_a_addr || l_r == ins_b_addr);
  assign raw_x = x_v && x_wen && (x_r == ins_a_addr || x_r == ins_b_addr);
  assign hazard = (HAZARD_CHECK != 0) && ins_valid && (raw_l || raw_x);
  assign ins_ready = step && !hazard;
  assign xfer = ins_valid && ins_ready;
  assign bram_a_addr = l_a;
  assign bram_b_addr = l_b;
  assign exec_valid = x_v;
  assign exec_pe_op = x_op;
  assign exec_dot_ctrl = x_dot;
  assign bram_r_addr = s_r;
  assign store_r_sel = s_rsel;
  assign bram_r_wen = s_v && s_wen && step;
  assign busy = l_v | x_v | s_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      {l_v, l_wen, l_rsel, l_a, l_b, l_r, l_op, l_dot} <= '0;
      {x_v, x_wen, x_rsel, x_r, x_op, x_dot} <= '0;
      {s_v, s_wen, s_rsel, s_r} <= '0;
      hazard_cnt <= '0;
    end else begin
      if (!stall) cnt <= step ? '0 : cnt + CW'(1);
      if (step) begin
        {s_v, s_wen, s_rsel, s_r} <= {x_v, x_wen, x_rsel, x_r};
        {x_v, x_wen, x_rsel, x_r, x_op, x_dot} <= {l_v, l_wen, l_rsel, l_r, l_op, l_dot};
        {l_v, l_wen, l_rsel, l_a, l_b, l_r, l_op, l_dot} <= xfer ?
          {1'b1, ins_wen, ins_r_sel, ins_a_addr, ins_b_addr, ins_r_addr, ins_pe_op, ins_dot_ctrl} : '0;
      end
      if (step && hazard && !(&hazard_cnt)) hazard_cnt <= hazard_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_simd_pipe_ctrl.sv
// tb_simd_pipe_ctrl: scoreboard bench over three parameterisations of simd_pipe_ctrl
module tb_simd_pipe_ctrl;
  logic clk = 0, rst = 1, stall = 0, iv = 0, iwen = 0, irsel = 0;
  logic [9:0] ia = 0, ib = 0, ir = 0;
  logic [3:0] iop = 0;
  logic [1:0] idot = 0;
  logic rdy [3], xv [3], stp [3], wen [3], rsel [3], busy [3];
  logic [9:0] baa [3], bba [3], bra [3];
  logic [3:0] xop [3];
  logic [1:0] xdot [3];
  logic [15:0] hc0, hc1;
  logic [1:0] hc2;
  typedef struct {logic [9:0] r; logic s; int t;} ent_t;
  ent_t q [$];
  ent_t e;
  int checks = 0, failures = 0, cyc = 0, sel = 0, extra = 0, nwr = 0, last_wr = -1, last_acc = -2;
  logic acc = 0;
  always #5 clk = ~clk;

  simd_pipe_ctrl #(.STEP_CYCLES(2), .HAZARD_CHECK(1)) u0 (.clk(clk), .rst(rst), .stall(stall),
    .ins_valid(iv), .ins_ready(rdy[0]), .ins_a_addr(ia), .ins_b_addr(ib), .ins_r_addr(ir), .ins_pe_op(iop),
    .ins_dot_ctrl(idot), .ins_wen(iwen), .ins_r_sel(irsel), .bram_a_addr(baa[0]), .bram_b_addr(bba[0]),
    .exec_valid(xv[0]), .exec_pe_op(xop[0]), .exec_dot_ctrl(xdot[0]), .step(stp[0]), .bram_r_addr(bra[0]),
    .bram_r_wen(wen[0]), .store_r_sel(rsel[0]), .busy(busy[0]), .hazard_cnt(hc0));
  simd_pipe_ctrl #(.STEP_CYCLES(2), .HAZARD_CHECK(0)) u1 (.clk(clk), .rst(rst), .stall(stall),
    .ins_valid(iv), .ins_ready(rdy[1]), .ins_a_addr(ia), .ins_b_addr(ib), .ins_r_addr(ir), .ins_pe_op(iop),
    .ins_dot_ctrl(idot), .ins_wen(iwen), .ins_r_sel(irsel), .bram_a_addr(baa[1]), .bram_b_addr(bba[1]),
    .exec_valid(xv[1]), .exec_pe_op(xop[1]), .exec_dot_ctrl(xdot[1]), .step(stp[1]), .bram_r_addr(bra[1]),
    .bram_r_wen(wen[1]), .store_r_sel(rsel[1]), .busy(busy[1]), .hazard_cnt(hc1));
  simd_pipe_ctrl #(.STEP_CYCLES(1), .HAZARD_CHECK(1), .CNT_WIDTH(2)) u2 (.clk(clk), .rst(rst), .stall(stall),
    .ins_valid(iv), .ins_ready(rdy[2]), .ins_a_addr(ia), .ins_b_addr(ib), .ins_r_addr(ir), .ins_pe_op(iop),
    .ins_dot_ctrl(idot), .ins_wen(iwen), .ins_r_sel(irsel), .bram_a_addr(baa[2]), .bram_b_addr(bba[2]),
    .exec_valid(xv[2]), .exec_pe_op(xop[2]), .exec_dot_ctrl(xdot[2]), .step(stp[2]), .bram_r_addr(bra[2]),
    .bram_r_wen(wen[2]), .store_r_sel(rsel[2]), .busy(busy[2]), .hazard_cnt(hc2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc = iv && rdy[sel] && !rst;
    if (wen[sel] && !rst) begin
      nwr++;
      last_wr = cyc;
      if (q.size() == 0) chk("spurious_wr", 1, 0);
      else begin
        e = q.pop_front();
        chk("wr_addr", 32'(bra[sel]), 32'(e.r));
        chk("wr_sel", 32'(rsel[sel]), 32'(e.s));
        chk("wr_lat", cyc, e.t);
      end
    end
    if (acc) begin
      last_acc = cyc;
      if (iwen) q.push_back('{ir, irsel, cyc + 3 * (sel == 2 ? 1 : 2) + extra});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic offer(input logic [9:0] a, input logic [9:0] b, input logic [9:0] r,
                       input logic w, input logic s, output int n);
    ia = a; ib = b; ir = r; iwen = w; irsel = s; iop = r[3:0]; idot = r[1:0]; iv = 1; n = 0;
    do begin tick(); n++; end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic restart(input int s);
    iv = 0; stall = 0; rst = 1; sel = s; extra = 0;
    tick(); tick();
    q.delete();
    rst = 0;
  endtask

  task automatic drain(input int n);
    iv = 0;
    for (int i = 0; i < n; i++) tick();
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int n, w0;
    rst = 1; iv = 1; ia = 10'h3ff; ib = 10'h155; ir = 10'h2aa; iwen = 1; irsel = 1; iop = 4'hf; idot = 2'h3;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_ready", 32'(rdy[0]), 0);
    chk("rst_outs", {baa[0], bba[0], bra[0], xv[0], xop[0], xdot[0], stp[0], wen[0], rsel[0]}, 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_hcnt", 32'(hc0), 0);
    rst = 0; iv = 0;
    tick();
    chk("post_rst_nowr", 32'(wen[0]), 0);

    restart(0);
    w0 = nwr;
    for (int i = 0; i < 4; i++) begin
      offer(10'(100 + 2 * i), 10'(101 + 2 * i), 10'(10 + i), 1'b1, 1'(i), n);
      chk("tput_wait", n, 2);
    end
    drain(12);
    chk("tput_writes", nwr - w0, 4);

    restart(0);
    offer(10'h20, 10'h20, 10'h20, 1'b1, 1'b0, n);
    chk("self_addr_wait", n, 2);
    offer(10'h20, 10'h3, 10'h21, 1'b1, 1'b1, n);
    chk("raw_wait", n, 6);
    chk("raw_hcnt", 32'(hc0), 2);
    chk("raw_retire_accept", last_acc, last_wr);
    drain(10);

    restart(1);
    offer(10'h20, 10'h20, 10'h20, 1'b1, 1'b0, n);
    offer(10'h20, 10'h3, 10'h21, 1'b1, 1'b1, n);
    chk("nochk_wait", n, 2);
    chk("nochk_hcnt", 32'(hc1), 0);
    drain(10);

    restart(0);
    w0 = nwr;
    extra = 5;
    offer(10'h1, 10'h2, 10'h40, 1'b1, 1'b1, n);
    iv = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_in_store", 32'(busy[0]), 1);
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_nowr", 32'(wen[0]), 0);
      chk("stall_nostep", 32'(stp[0]), 0);
      tick();
    end
    stall = 0;
    drain(10);
    chk("stall_writes", nwr - w0, 1);
    extra = 0;

    restart(2);
    w0 = nwr;
    for (int i = 0; i < 8; i++) begin
      offer(10'(200 + i), 10'(300 + i), 10'(50 + i), 1'(i != 3), 1'(i), n);
      chk("sc1_wait", n, 1);
      chk("sc1_load_a", 32'(baa[2]), 200 + i);
      if (i > 0) chk("sc1_exec_op", {xv[2], xop[2]}, {1'b1, 4'(50 + i - 1)});
      if (i > 2) chk("sc1_busy", 32'(busy[2]), 1);
    end
    iv = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sc1_busy_tail", 32'(busy[2]), 1);
      tick();
    end
    chk("sc1_busy_drop", 32'(busy[2]), 0);
    chk("sc1_writes", nwr - w0, 7);
    chk("sc1_drained", q.size(), 0);

    restart(2);
    for (int k = 0; k < 2; k++) begin
      offer(10'h5, 10'h6, 10'h70, 1'b1, 1'b0, n);
      offer(10'h70, 10'h7, 10'h71, 1'b1, 1'b0, n);
      chk("sat_wait", n, 3);
      chk("sat_hcnt", 32'(hc2), k == 0 ? 2 : 3);
    end
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/simd_pipe_ctrl.md
Name: simd_pipe_ctrl

Overview:
Parametrised three-stage (Load/Execute/Store) control pipeline for the SIMD datapath. It accepts decoded instructions over a valid/ready handshake and steps the pipeline once every STEP_CYCLES clocks. It carries a valid bit per stage, honours an external stall, and interlocks read-after-write hazards on BRAM addresses. It drives BRAM addresses, execute-unit control and the execute-phase strobe, and keeps a saturating hazard-stall counter.

Parameters:
ADDR_WIDTH, 10, BRAM word address width
OP_SEL_WIDTH, 4, PE opcode select width
STEP_CYCLES, 2, clocks per pipeline step (>=1)
HAZARD_CHECK, 1, 1 = RAW interlock enabled; 0 = never interlock
CNT_WIDTH, 16, hazard-stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  external freeze of the divider and pipeline
ins_valid  in  1  instruction offered
ins_ready  out  1  instruction accepted this cycle
ins_a_addr  in  ADDR_WIDTH  source A address
ins_b_addr  in  ADDR_WIDTH  source B address
ins_r_addr  in  ADDR_WIDTH  destination address
ins_pe_op  in  OP_SEL_WIDTH  PE operation
ins_dot_ctrl  in  2  dot-product control
ins_wen  in  1  instruction writes BRAM
ins_r_sel  in  1  0 = PE result, 1 = dot result
bram_a_addr  out  ADDR_WIDTH  Load-stage A read address
bram_b_addr  out  ADDR_WIDTH  Load-stage B read address
exec_valid  out  1  Execute stage holds an instruction
exec_pe_op  out  OP_SEL_WIDTH  Execute-stage opcode
exec_dot_ctrl  out  2  Execute-stage dot control
step  out  1  pipeline advance strobe (feeds execute unit phase)
bram_r_addr  out  ADDR_WIDTH  Store-stage write address
bram_r_wen  out  1  BRAM write enable
store_r_sel  out  1  store result select
busy  out  1  any stage valid
hazard_cnt  out  CNT_WIDTH  saturating count of hazard-blocked steps

Behaviour:
- Reset (rst=1 at posedge): divider counter cnt=0; all stage valid bits=0; all stage fields=0; hazard_cnt=0. Every output is 0 during and after reset until the state changes. Reset mid-operation discards in-flight instructions without any write.
- Divider: cnt counts 0..STEP_CYCLES-1, then wraps to 0. cnt holds while stall=1. Combinational step = (cnt==STEP_CYCLES-1) && !stall. With STEP_CYCLES=1, step = !stall.
- Hazard (comb.): hazard = HAZARD_CHECK && ins_valid && any of {L, X} with valid && wen && r_addr ∈ {ins_a_addr, ins_b_addr}. The S stage is never compared, because it retires on this step.
- ins_ready = step && !hazard. ins_ready is independent of ins_valid except through hazard. Transfer occurs when ins_valid && ins_ready.
- On step: S <= X; X <= L; L <= the offered instruction with valid=1 if transferred, else a bubble (valid=0, all fields 0).
- No step: all stages hold.
- Outputs are combinational from stage registers:
  - bram_a_addr and bram_b_addr come from L.
  - exec_valid, exec_pe_op and exec_dot_ctrl come from X.
  - bram_r_addr and store_r_sel come from S.
  - bram_r_wen = S.valid && S.wen && step. Each instruction writes exactly once, on the last cycle of its Store window.
- Stall asserted on the would-be step cycle: no write, no advance. The write occurs on the first step cycle after stall drops.
- Latency: an instruction accepted at step k writes at step k+3, i.e. 3*STEP_CYCLES clocks later with no stall.
- hazard_cnt increments by 1 on each cycle with step && ins_valid && hazard. It saturates at all-ones.
- busy = L.valid | X.valid | S.valid.
- Equal A/B/R addresses within a single instruction are not a hazard for that instruction.

Test Plan:
- Reset: hold rst=1 for 3 cycles with ins_valid=1 -> all outputs 0, ins_ready=0, and no write after release until the first step.
- Throughput, STEP_CYCLES=2: 4 independent instructions with r_addr=10..13, sources 100..107 -> ins_ready pulses every 2nd clock; bram_r_wen pulses once each, with r_addr 10,11,12,13, each 6 clocks after acceptance.
- RAW interlock: I0 writes 0x20; I1 reads a_addr=0x20 -> I1 is blocked for 2 steps (I0 in L, then in X); hazard_cnt=2; I1 is accepted on the step where I0 retires from S.
- HAZARD_CHECK=0, same sequence -> I1 is accepted on the step immediately after I0; hazard_cnt stays 0.
- Stall: assert stall for 5 cycles while an instruction is in S -> bram_r_wen stays 0 and cnt is frozen; exactly one write occurs after release.
- STEP_CYCLES=1 with back-to-back independent instructions -> one accept and, after the 3-cycle fill, one write per clock; busy=1 throughout; busy drops 3 cycles after ins_valid falls.
